// File: rtl/uart_rx_framer.sv
// Length-delimited, checksummed frame extractor sitting behind uart_rx; replays good payloads on valid/ready.
// Optional frame statistics counters are enabled by defining UART_RX_FRAMER_STATS_EN.
module uart_rx_framer #(
   parameter logic [7:0] SOF_BYTE       = 8'h7E,
   parameter int         MAX_LEN        = 16,
   parameter int         TIMEOUT_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        uart_rx_valid,
   input  logic [7:0]  uart_rx_data,
   input  logic        uart_rx_break,
   output logic        frm_valid,
   input  logic        frm_ready,
   output logic [7:0]  frm_data,
   output logic        frm_last,
   output logic [7:0]  frm_len,
   output logic        err_pulse,
   output logic [1:0]  err_code,
   output logic        drop_pulse
`ifdef UART_RX_FRAMER_STATS_EN
   ,
   output logic [15:0] frm_ok_count,
   output logic [15:0] frm_err_count
`endif
);

   localparam int IW    = $clog2(MAX_LEN + 1);
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int DEPTH = 1 << IW;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LEN     = 3'd1;
   localparam logic [2:0] S_PAYLOAD = 3'd2;
   localparam logic [2:0] S_CHECK   = 3'd3;
   localparam logic [2:0] S_OUTPUT  = 3'd4;

   localparam logic [1:0] ERR_LEN   = 2'd0;
   localparam logic [1:0] ERR_CHK   = 2'd1;
   localparam logic [1:0] ERR_TOUT  = 2'd2;
   localparam logic [1:0] ERR_BREAK = 2'd3;

   logic [2:0]    state_q, state_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    sum_q, sum_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] rdIdx_q, rdIdx_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          errPulse_q, errPulse_d;
   logic [1:0]    errCode_q, errCode_d;
   logic          dropPulse_q, dropPulse_d;
   logic          memWe;
   logic [7:0]    idxNext8;
   logic          rdLast;
   logic [7:0]    mem_q [0:DEPTH-1];

   assign idxNext8 = 8'(idx_q) + 8'd1;
   assign rdLast   = (8'(rdIdx_q) == (len_q - 8'd1));

   // Timer value is "clocks since the last accepted byte", so it reads 1 on the cycle after a byte.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      sum_d       = sum_q;
      idx_d       = idx_q;
      rdIdx_d     = rdIdx_q;
      timer_d     = '0;
      errPulse_d  = 1'b0;
      errCode_d   = errCode_q;
      dropPulse_d = 1'b0;
      memWe       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (uart_rx_valid && (uart_rx_data == SOF_BYTE)) begin
               state_d = S_LEN;
               timer_d = TW'(1);
            end
         end
         S_LEN, S_PAYLOAD, S_CHECK: begin
            if (uart_rx_break) begin
               errPulse_d = 1'b1;
               errCode_d  = ERR_BREAK;
               state_d    = S_IDLE;
            end else if (uart_rx_valid) begin
               timer_d = TW'(1);
               case (state_q)
                  S_LEN: begin
                     if ((uart_rx_data == 8'd0) || (uart_rx_data > 8'(MAX_LEN))) begin
                        errPulse_d = 1'b1;
                        errCode_d  = ERR_LEN;
                        state_d    = S_IDLE;
                     end else begin
                        len_d   = uart_rx_data;
                        sum_d   = uart_rx_data;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                     end
                  end
                  S_PAYLOAD: begin
                     memWe = 1'b1;
                     sum_d = sum_q + uart_rx_data;
                     idx_d = idx_q + 1'b1;
                     if (idxNext8 == len_q) begin
                        state_d = S_CHECK;
                     end
                  end
                  default: begin
                     if (uart_rx_data == sum_q) begin
                        rdIdx_d = '0;
                        state_d = S_OUTPUT;
                     end else begin
                        errPulse_d = 1'b1;
                        errCode_d  = ERR_CHK;
                        state_d    = S_IDLE;
                     end
                  end
               endcase
            end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
               errPulse_d = 1'b1;
               errCode_d  = ERR_TOUT;
               state_d    = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_OUTPUT: begin
            if (uart_rx_valid) begin
               dropPulse_d = 1'b1;
            end
            if (frm_ready) begin
               if (rdLast) begin
                  state_d = S_IDLE;
               end else begin
                  rdIdx_d = rdIdx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if ((state_d == S_IDLE) || (state_d == S_OUTPUT)) begin
         timer_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         rdIdx_q     <= '0;
         timer_q     <= '0;
         errPulse_q  <= 1'b0;
         errCode_q   <= '0;
         dropPulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         rdIdx_q     <= rdIdx_d;
         timer_q     <= timer_d;
         errPulse_q  <= errPulse_d;
         errCode_q   <= errCode_d;
         dropPulse_q <= dropPulse_d;
      end
   end

   // Payload storage has no reset; only entries written by the current frame are ever read.
   always_ff @(posedge clk) begin
      if (memWe) begin
         mem_q[idx_q] <= uart_rx_data;
      end
   end

   assign frm_valid  = (state_q == S_OUTPUT);
   assign frm_data   = frm_valid ? mem_q[rdIdx_q] : 8'h00;
   assign frm_last   = frm_valid && rdLast;
   assign frm_len    = len_q;
   assign err_pulse  = errPulse_q;
   assign err_code   = errCode_q;
   assign drop_pulse = dropPulse_q;

`ifdef UART_RX_FRAMER_STATS_EN
   logic [15:0] okCount_q;
   logic [15:0] errCount_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         okCount_q  <= '0;
         errCount_q <= '0;
      end else begin
         if ((state_q == S_CHECK) && (state_d == S_OUTPUT) && (okCount_q != 16'hFFFF)) begin
            okCount_q <= okCount_q + 16'd1;
         end
         if (errPulse_d && (errCount_q != 16'hFFFF)) begin
            errCount_q <= errCount_q + 16'd1;
         end
      end
   end

   assign frm_ok_count  = okCount_q;
   assign frm_err_count = errCount_q;
`endif

endmodule
